apb_regbank_rw: RTL and testbench

Parametrised APB4 slave register bank; next generation of the fixed 3-status/3-control APB I/O block.
- Generalised to NUM_STAT read-only status words and NUM_CTRL read/write control words.
- Adds PSTRB byte-lane writes, programmable wait states, PSLVERR on unmapped or read-only access, and an optional status-change interrupt.
- Sits between the APB bridge and peripheral control/status wiring.

---
 rtl/apb_regbank_pkg.sv | 40 ++++
 rtl/apb_regbank_rw_wait_ctrl.sv | 99 +++++++++
 rtl/apb_regbank_rw.sv | 210 +++++++++++++++++++++
 tb/tb_apb_regbank_rw.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_regbank_pkg.sv
// -----------------------------------------------------------------------------
// apb_regbank_pkg
// Shared types and constants for the apb_regbank_rw register bank:
//   - apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   - dec_e       : address-decode result
//   - byte offsets of the register regions
//   - in_range()  : helper that tests whether an offset falls in a word array
// -----------------------------------------------------------------------------
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [2:0] {
        DEC_NONE     = 3'd0,
        DEC_STAT     = 3'd1,
        DEC_CTRL     = 3'd2,
        DEC_ID       = 3'd3,
        DEC_IRQ_STAT = 3'd4,
        DEC_IRQ_MASK = 3'd5
    } dec_e;

    localparam logic [31:0] STAT_BASE    = 32'h0000_0000;
    localparam logic [31:0] CTRL_BASE    = 32'h0000_0040;
    localparam logic [31:0] ID_OFS       = 32'h0000_007C;
    localparam logic [31:0] IRQ_STAT_OFS = 32'h0000_0080;
    localparam logic [31:0] IRQ_MASK_OFS = 32'h0000_0084;

    // True when a word-aligned byte offset lies inside an array of 'count'
    // 32-bit-spaced words starting at 'base'.
    function automatic logic in_range(input logic [31:0] ofs,
                                      input logic [31:0] base,
                                      input logic [31:0] count);
        return (ofs >= base) && (ofs < (base + (count << 32'd2)));
    endfunction

endpackage

// File: rtl/apb_regbank_rw_wait_ctrl.sv
// -----------------------------------------------------------------------------
// apb_wait_ctrl
// APB transfer FSM with programmable wait states. Produces PREADY and the
// write-commit strobe for the register bank.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_clk_en       : 0 holds FSM and counter and forces o_pready low
//   i_psel         : APB select
//   i_penable      : APB enable (access phase)
//   o_pready       : transfer complete this cycle
//   o_commit       : side effects (writes, W1C) take place this cycle
//   o_access       : FSM is in the ACCESS state (read data may be driven)
// The SETUP state is recognised combinationally from IDLE while the master
// presents its setup phase, so a zero-wait transfer takes the standard two
// cycles and each wait state adds exactly one.
// -----------------------------------------------------------------------------
module apb_wait_ctrl
    import apb_regbank_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_en,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready,
    output logic o_commit,
    output logic o_access
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    apb_state_e r_state;
    apb_state_e w_state_cur;
    apb_state_e w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    // Effective current state: a setup phase seen from IDLE is the SETUP state.
    always_comb begin
        w_state_cur = r_state;
        if ((r_state == IDLE) && i_psel && !i_penable) begin
            w_state_cur = SETUP;
        end else begin
            w_state_cur = r_state;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = r_cnt;
        case (w_state_cur)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_cnt_nxt   = WAIT_CNT;
            end
            ACCESS: begin
                if (!i_psel) begin
                    // Master abandoned the transfer: nothing is committed.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and counter registers; frozen while the clock enable is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else if (i_clk_en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end else begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
        end
    end

    assign o_pready = i_clk_en & (r_state == ACCESS) & (r_cnt == 4'd0) & i_psel;
    assign o_commit = o_pready & i_penable;
    assign o_access = (r_state == ACCESS);

endmodule

// File: rtl/apb_regbank_rw.sv
// -----------------------------------------------------------------------------
// apb_regbank_rw
// APB4 slave register bank: NUM_STAT read-only status words, NUM_CTRL
// read/write control words with byte strobes, a read-only ID word,
// programmable wait states and PSLVERR on unmapped / read-only writes.
// Optional feature macro: APB_REGBANK_IRQ_EN (status-change interrupt with
// IRQ_STATUS (W1C) at 0x80 and IRQ_MASK at 0x84). Without it irq_o is 0 and
// 0x80/0x84 are unmapped.
// Ports:
//   PCLK, PRESET        : clock, asynchronous active-high reset
//   clk_en              : 0 freezes all state and holds PREADY low
//   PSEL/PENABLE/PWRITE : APB control
//   PADDR, PWDATA, PSTRB: APB address (bits [1:0] ignored), data, strobes
//   PRDATA/PREADY/PSLVERR : APB response
//   control_o           : control words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   status_i            : status words, same packing, sampled live
//   irq_o               : registered interrupt request
// -----------------------------------------------------------------------------
module apb_regbank_rw
    import apb_regbank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_STAT    = 4,
    parameter int unsigned NUM_CTRL    = 4,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] CTRL_RESET  = 32'h0000_1234,
    parameter logic [31:0] ID_VALUE    = 32'h0021_6948
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           clk_en,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] control_o,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] status_i,
    output logic                           irq_o
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic                           w_pready;
    logic                           w_commit;
    logic                           w_access;
    logic [31:0]                    w_ofs;
    logic [3:0]                     w_idx;
    dec_e                           w_dec;
    logic                           w_err;
    logic                           w_wr;
    logic [DATA_WIDTH-1:0]          w_mask;
    logic [DATA_WIDTH-1:0]          w_wdata_m;
    logic [DATA_WIDTH-1:0]          w_rdata;
    logic [NUM_CTRL*DATA_WIDTH-1:0] r_ctrl;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clk_en  (clk_en),
        .i_psel    (PSEL),
        .i_penable (PENABLE),
        .o_pready  (w_pready),
        .o_commit  (w_commit),
        .o_access  (w_access)
    );

    // Word-aligned byte offset; the two low address bits are don't-care.
    assign w_ofs = 32'(PADDR) & ~32'd3;
    assign w_idx = w_ofs[5:2];

    // Address decode.
    always_comb begin
        w_dec = DEC_NONE;
        if (in_range(w_ofs, STAT_BASE, 32'(NUM_STAT))) begin
            w_dec = DEC_STAT;
        end else if (in_range(w_ofs, CTRL_BASE, 32'(NUM_CTRL))) begin
            w_dec = DEC_CTRL;
        end else if (w_ofs == ID_OFS) begin
            w_dec = DEC_ID;
`ifdef APB_REGBANK_IRQ_EN
        end else if (w_ofs == IRQ_STAT_OFS) begin
            w_dec = DEC_IRQ_STAT;
        end else if (w_ofs == IRQ_MASK_OFS) begin
            w_dec = DEC_IRQ_MASK;
`endif
        end else begin
            w_dec = DEC_NONE;
        end
    end

    // Byte strobes expanded to a bit mask; strobe-masked write data.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            w_mask[b*8 +: 8] = {8{PSTRB[b]}};
        end
        w_wdata_m = PWDATA & w_mask;
    end

    assign w_err = (w_dec == DEC_NONE) |
                   (PWRITE & ((w_dec == DEC_STAT) | (w_dec == DEC_ID)));
    assign w_wr  = w_commit & PWRITE & ~w_err;

    // Control words: byte-lane writes committed on the completing cycle only.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_ctrl <= {NUM_CTRL{DATA_WIDTH'(CTRL_RESET)}};
        end else if (clk_en && w_wr && (w_dec == DEC_CTRL)) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (w_idx == 4'(i)) begin
                    r_ctrl[i*DATA_WIDTH +: DATA_WIDTH] <=
                        (r_ctrl[i*DATA_WIDTH +: DATA_WIDTH] & ~w_mask) | w_wdata_m;
                end else begin
                    r_ctrl[i*DATA_WIDTH +: DATA_WIDTH] <= r_ctrl[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end else begin
            r_ctrl <= r_ctrl;
        end
    end

    assign control_o = r_ctrl;

`ifdef APB_REGBANK_IRQ_EN
    logic [NUM_STAT*DATA_WIDTH-1:0] r_status_q;
    logic [NUM_STAT-1:0]            r_irq_stat;
    logic [NUM_STAT-1:0]            r_irq_mask;
    logic                           r_irq;
    logic [NUM_STAT-1:0]            w_chg;
    logic [NUM_STAT-1:0]            w_irq_clr;
    logic [NUM_STAT-1:0]            w_mask_wr;

    // Per-word change detect and software clear / mask-write requests.
    always_comb begin
        w_chg     = '0;
        w_irq_clr = '0;
        w_mask_wr = '0;
        for (int i = 0; i < NUM_STAT; i++) begin
            w_chg[i] = (status_i[i*DATA_WIDTH +: DATA_WIDTH] !=
                        r_status_q[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        if (w_wr && (w_dec == DEC_IRQ_STAT)) begin
            w_irq_clr = w_wdata_m[NUM_STAT-1:0];
        end else begin
            w_irq_clr = '0;
        end
        if (w_wr && (w_dec == DEC_IRQ_MASK)) begin
            w_mask_wr = w_mask[NUM_STAT-1:0];
        end else begin
            w_mask_wr = '0;
        end
    end

    // Interrupt state; a hardware set beats a same-cycle W1C clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_status_q <= '0;
            r_irq_stat <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else if (clk_en) begin
            r_status_q <= status_i;
            r_irq_stat <= (r_irq_stat & ~w_irq_clr) | w_chg;
            r_irq_mask <= (r_irq_mask & ~w_mask_wr) | (w_wdata_m[NUM_STAT-1:0] & w_mask_wr);
            r_irq      <= |(r_irq_stat & r_irq_mask);
        end else begin
            r_status_q <= r_status_q;
            r_irq_stat <= r_irq_stat;
            r_irq_mask <= r_irq_mask;
            r_irq      <= r_irq;
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    // Read-data mux; driven only for reads in the ACCESS state.
    always_comb begin
        w_rdata = '0;
        if (w_access && !PWRITE) begin
            case (w_dec)
                DEC_STAT:     w_rdata = status_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
                DEC_CTRL:     w_rdata = r_ctrl[w_idx*DATA_WIDTH +: DATA_WIDTH];
                DEC_ID:       w_rdata = DATA_WIDTH'(ID_VALUE);
`ifdef APB_REGBANK_IRQ_EN
                DEC_IRQ_STAT: w_rdata = DATA_WIDTH'(r_irq_stat);
                DEC_IRQ_MASK: w_rdata = DATA_WIDTH'(r_irq_mask);
`endif
                default:      w_rdata = '0;
            endcase
        end else begin
            w_rdata = '0;
        end
    end

    assign PRDATA  = w_rdata;
    assign PREADY  = w_pready;
    assign PSLVERR = w_pready & w_err;

endmodule

// File: tb/tb_apb_regbank_rw.sv
module tb_apb_regbank_rw;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int NC = 4;
    localparam int WS = 3;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic           clk_en;
    logic           PSEL;
    logic           PENABLE;
    logic           PWRITE;
    logic [AW-1:0]  PADDR;
    logic [DW-1:0]  PWDATA;
    logic [3:0]     PSTRB;
    logic [DW-1:0]  PRDATA;
    logic           PREADY;
    logic           PSLVERR;
    logic [NC*DW-1:0] control_o;
    logic [NS*DW-1:0] status_i;
    logic           irq_o;

    apb_regbank_rw #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_STAT (NS), .NUM_CTRL (NC),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK (PCLK), .PRESET (PRESET), .clk_en (clk_en),
        .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
        .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB),
        .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR),
        .control_o (control_o), .status_i (status_i), .irq_o (irq_o)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ctrl [NC];
    logic        bump_on_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("%s_ctrl%0d", name, i), control_o[i*DW +: DW], exp_ctrl[i]);
        end
    endtask

    // Monitor: every completed transfer is compared against the scoreboard.
    always @(negedge PCLK) begin
        exp_t e;
        if (PREADY === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pready: got PREADY=1 expected no transfer");
            end else begin
                e = sb.pop_front();
                check({e.name, "_rdata"}, PRDATA, e.rdata);
                check({e.name, "_slverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
            end
        end
    end

    // One APB transfer; optional clk_en freeze at access cycle 'freeze_at'.
    task automatic apb(input string name, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int freeze_at, output int n);
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.name  = name;
        sb.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
            if (PREADY === 1'b1 && bump_on_ready) begin
                status_i[63:32] = status_i[63:32] ^ 32'h0000_0001;
            end
            if (n == freeze_at && PREADY !== 1'b1) begin
                clk_en = 1'b0;
                repeat (5) begin
                    @(negedge PCLK);
                    check({name, "_frozen_pready"}, {31'd0, PREADY}, 32'd0);
                    check_ctrl({name, "_frozen"});
                end
                clk_en = 1'b1;
            end
        end while (PREADY !== 1'b1 && n < 40);
        if (PREADY !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no PREADY after %0d cycles expected %0d", name, n, WS + 1);
            void'(sb.pop_back());
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        PRESET = 1'b1; clk_en = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'h0; PSTRB = 4'h0;
        status_i = {32'h0000_0000, 32'h0000_002A, 32'h0000_7832, 32'h9C4E_9A31};
        for (int i = 0; i < NC; i++) exp_ctrl[i] = 32'h0000_1234;

        // Reset state
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check_ctrl("rst");
        @(posedge PCLK); #1 PRESET = 1'b0;

        // 1. Reads of status, control and ID
        apb("rd_stat0", 1'b0, 8'h00, 32'h0, 4'h0, 32'h9C4E_9A31, 1'b0, 0, n);
        check("lat_read", 32'(n), 32'(WS + 1));
        apb("rd_stat1", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_7832, 1'b0, 0, n);
        apb("rd_stat2", 1'b0, 8'h08, 32'h0, 4'h0, 32'h0000_002A, 1'b0, 0, n);
        apb("rd_stat3", 1'b0, 8'h0F, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 0, n);
        apb("rd_ctrl1", 1'b0, 8'h44, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 0, n);
        apb("rd_id",    1'b0, 8'h7C, 32'h0, 4'h0, 32'h0021_6948, 1'b0, 0, n);

        // 2. Byte-strobe writes
        apb("wr_clr0", 1'b1, 8'h40, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 0, n);
        exp_ctrl[0] = 32'h0000_0000;
        apb("wr_strb5", 1'b1, 8'h40, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 0, n);
        apb("rd_strb5", 1'b0, 8'h40, 32'h0, 4'h0, 32'h0022_0044, 1'b0, 0, n);
        exp_ctrl[0] = 32'h0022_0044;
        check_ctrl("strb5");
        apb("wr_full", 1'b1, 8'h40, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 0, n);
        apb("rd_full", 1'b0, 8'h40, 32'h0, 4'h0, 32'h1122_3344, 1'b0, 0, n);
        exp_ctrl[0] = 32'h1122_3344;
        check_ctrl("full");

        // 3. Wait states, commit point and reset mid-transfer
        apb("wr_c2", 1'b1, 8'h48, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0, 0, n);
        check("lat_write", 32'(n), 32'(WS + 1));
        exp_ctrl[2] = 32'hAAAA_5555;
        check_ctrl("c2");
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h48; PWDATA = 32'h0F0F_0F0F; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge PCLK);
            check($sformatf("wait%0d_pready", k), {31'd0, PREADY}, 32'd0);
            check_ctrl($sformatf("wait%0d", k));
        end
        PRESET = 1'b1;
        #1;
        check("midrst_pready", {31'd0, PREADY}, 32'd0);
        for (int i = 0; i < NC; i++) exp_ctrl[i] = 32'h0000_1234;
        check_ctrl("midrst");
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1 PRESET = 1'b0;
        @(negedge PCLK);
        check("post_rst_pready", {31'd0, PREADY}, 32'd0);

        // 4. Error responses
        apb("wr_stat", 1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0, n);
        apb("rd_unmap3c", 1'b0, 8'h3C, 32'h0, 4'h0, 32'h0, 1'b1, 0, n);
        apb("rd_stat0_again", 1'b0, 8'h00, 32'h0, 4'h0, 32'h9C4E_9A31, 1'b0, 0, n);
        apb("wr_id", 1'b1, 8'h7C, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0, n);
        apb("rd_unmap50", 1'b0, 8'h50, 32'h0, 4'h0, 32'h0, 1'b1, 0, n);
        apb("wr_ctrl_unmap", 1'b1, 8'h50, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0, n);
        apb("wr_nostrb", 1'b1, 8'h44, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0, n);
        check_ctrl("err");
`ifndef APB_REGBANK_IRQ_EN
        apb("wr_irq_off", 1'b1, 8'h80, 32'h0000_0001, 4'hF, 32'h0, 1'b1, 0, n);
        apb("rd_irq_off", 1'b0, 8'h84, 32'h0, 4'h0, 32'h0, 1'b1, 0, n);
        check("irq_tied", {31'd0, irq_o}, 32'd0);
`endif

        // 6. Clock-enable freeze mid-ACCESS
        apb("wr_freeze", 1'b1, 8'h4C, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1, n);
        check("lat_freeze", 32'(n), 32'(WS + 1));
        exp_ctrl[3] = 32'h0BAD_F00D;
        check_ctrl("freeze");
        apb("rd_freeze", 1'b0, 8'h4C, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 0, n);

`ifdef APB_REGBANK_IRQ_EN
        // 5. Status-change interrupt
        apb("irq_clr_all", 1'b1, 8'h80, 32'h0000_FFFF, 4'hF, 32'h0, 1'b0, 0, n);
        apb("irq_rd0", 1'b0, 8'h80, 32'h0, 4'h0, 32'h0, 1'b0, 0, n);
        apb("irq_mask", 1'b1, 8'h84, 32'h0000_0002, 4'hF, 32'h0, 1'b0, 0, n);
        apb("irq_rd_mask", 1'b0, 8'h84, 32'h0, 4'h0, 32'h0000_0002, 1'b0, 0, n);
        @(negedge PCLK);
        check("irq_idle", {31'd0, irq_o}, 32'd0);
        status_i[63:32] = 32'h0000_7833;
        @(negedge PCLK);
        check("irq_not_yet", {31'd0, irq_o}, 32'd0);
        @(negedge PCLK);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        apb("irq_rd_set", 1'b0, 8'h80, 32'h0, 4'h0, 32'h0000_0002, 1'b0, 0, n);
        apb("irq_w1c", 1'b1, 8'h80, 32'h0000_0002, 4'hF, 32'h0, 1'b0, 0, n);
        @(negedge PCLK);
        @(negedge PCLK);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        bump_on_ready = 1'b1;
        apb("irq_w1c_race", 1'b1, 8'h80, 32'h0000_0002, 4'hF, 32'h0, 1'b0, 0, n);
        bump_on_ready = 1'b0;
        apb("irq_rd_race", 1'b0, 8'h80, 32'h0, 4'h0, 32'h0000_0002, 1'b0, 0, n);
        check("irq_race", {31'd0, irq_o}, 32'd1);
`endif

        repeat (3) @(posedge PCLK);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
